// File: rtl/fifo_read_stream_adapter_pkg.sv
// ============================================================================
//  Module   : fifo_read_stream_adapter_pkg
//  Brief    : Shared widths, buffer geometry and helpers for the FIFO read
//             stream adapter and its 2-entry skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_read_stream_adapter_pkg;

    localparam int c_DEFAULT_DATA_WIDTH  = 8;
    localparam int c_DEFAULT_COUNT_WIDTH = 16;
    localparam int c_BUF_DEPTH           = 2;
    localparam int c_OCC_WIDTH           = 2;

    typedef logic [c_OCC_WIDTH-1:0] occ_t;

    // True while the buffer can still take a word this cycle.
    function automatic logic buf_has_room(input occ_t occ);
        return occ < c_OCC_WIDTH'(c_BUF_DEPTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_read_stream_adapter_stream_buffer_2entry.sv
// ============================================================================
//  Module   : stream_buffer_2entry
//  Brief    : Two-entry in-order queue with head/tail pointers and an
//             occupancy register; storage itself is not reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_buffer_2entry
    import fifo_read_stream_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output occ_t                  o_count
);

    logic [DATA_WIDTH-1:0] r_mem [c_BUF_DEPTH];
    logic                  r_head;
    logic                  r_tail;
    occ_t                  r_count;

    logic w_push;
    logic w_pop;

    assign w_pop  = i_pop  & (r_count != '0);
    assign w_push = i_push & buf_has_room(r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ~r_tail;
            if (w_pop)  r_head <= ~r_head;
            // Simultaneous push and pop leaves occupancy untouched.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + occ_t'(1);
                2'b01:   r_count <= r_count - occ_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_push_data;
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_read_stream_adapter.sv
// ============================================================================
//  Module   : fifo_read_stream_adapter
//  Brief    : Turns an async-FIFO read port into a valid/ready stream through
//             a 2-entry buffer; counts accepted stream transfers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_stream_adapter
    import fifo_read_stream_adapter_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = c_DEFAULT_COUNT_WIDTH
) (
    input  logic                   read_clk,
    input  logic                   read_reset,
    input  logic                   stream_enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  read_data,
    output logic                   read_enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [c_OCC_WIDTH-1:0] out_count,
    output logic [COUNT_WIDTH-1:0] transfer_count
);

    occ_t                   w_occ;
    logic [DATA_WIDTH-1:0]  w_head_data;
    logic                   w_accept;
    logic [COUNT_WIDTH-1:0] r_transfer_count;

    // Fetch decision uses only registered occupancy, never out_ready, so the
    // FIFO pop strobe has no combinational path from the stream sink.
    assign read_enable = ~read_reset & stream_enable & ~fifo_empty & buf_has_room(w_occ);
    assign out_valid   = ~read_reset & (w_occ != '0);
    assign out_count   = read_reset ? '0 : w_occ;
    assign out_data    = w_head_data;
    assign w_accept    = out_valid & out_ready;

    stream_buffer_2entry #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clk         (read_clk),
        .rst         (read_reset),
        .i_push      (read_enable),
        .i_push_data (read_data),
        .i_pop       (w_accept),
        .o_head_data (w_head_data),
        .o_count     (w_occ)
    );

    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            r_transfer_count <= '0;
        end else if (w_accept) begin
            r_transfer_count <= r_transfer_count + COUNT_WIDTH'(1);
        end
    end

    assign transfer_count = r_transfer_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_stream_adapter.sv
// ============================================================================
//  Module   : tb_fifo_read_stream_adapter
//  Brief    : Self-checking bench; a queue-based FIFO and stream model drive
//             two adapter instances (16-bit and 4-bit transfer counters).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_read_stream_adapter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fe;
    logic       rdy;
    logic [7:0] rd;

    logic        re_a, ov_a, re_b, ov_b;
    logic [7:0]  od_a, od_b;
    logic [1:0]  oc_a, oc_b;
    logic [15:0] tc_a;
    logic [3:0]  tc_b;

    logic [7:0] fifo_q [$];
    logic [7:0] sb     [$];
    int         tc_model = 0;
    int         checks   = 0;
    int         fails    = 0;

    always #5 clk = ~clk;

    fifo_read_stream_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut_a (
        .read_clk(clk), .read_reset(rst), .stream_enable(en), .fifo_empty(fe),
        .read_data(rd), .read_enable(re_a), .out_valid(ov_a), .out_ready(rdy),
        .out_data(od_a), .out_count(oc_a), .transfer_count(tc_a)
    );

    fifo_read_stream_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_b (
        .read_clk(clk), .read_reset(rst), .stream_enable(en), .fifo_empty(fe),
        .read_data(rd), .read_enable(re_b), .out_valid(ov_b), .out_ready(rdy),
        .out_data(od_b), .out_count(oc_b), .transfer_count(tc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present FIFO head, check outputs against the model, then
    // advance the model by the rules (pop on accept, push on fetch).
    task automatic cycle();
        logic exp_re, exp_v;
        int   occ;
        fe = (fifo_q.size() == 0);
        rd = fe ? 8'($urandom) : fifo_q[0];
        #1;
        occ    = rst ? 0 : sb.size();
        exp_re = !rst && en && !fe && (sb.size() < 2);
        exp_v  = (occ != 0);
        chk("a.read_enable", 32'(re_a), 32'(exp_re));
        chk("b.read_enable", 32'(re_b), 32'(exp_re));
        chk("a.out_valid",   32'(ov_a), 32'(exp_v));
        chk("b.out_valid",   32'(ov_b), 32'(exp_v));
        chk("a.out_count",   32'(oc_a), 32'(occ));
        chk("b.out_count",   32'(oc_b), 32'(occ));
        if (exp_v) begin
            chk("a.out_data", 32'(od_a), 32'(sb[0]));
            chk("b.out_data", 32'(od_b), 32'(sb[0]));
        end
        chk("a.transfer_count", 32'(tc_a), 32'(tc_model % 65536));
        chk("b.transfer_count", 32'(tc_b), 32'(tc_model % 16));
        @(posedge clk);
        if (rst) begin
            sb.delete();
            tc_model = 0;
        end else begin
            if (exp_v && rdy) begin
                void'(sb.pop_front());
                tc_model++;
            end
            if (exp_re) sb.push_back(fifo_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rdy = 1'b0; fe = 1'b0; rd = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with a non-empty FIFO: nothing fetched, all idle.
        fifo_q.push_back(8'h11);
        en = 1'b1;
        repeat (2) cycle();
        fifo_q.delete();
        rst = 1'b0;
        cycle();

        // Single word with backpressure, then drain.
        fifo_q.push_back(8'hA5);
        rdy = 1'b0;
        repeat (3) cycle();
        rdy = 1'b1;
        repeat (2) cycle();

        // Backpressure fills the buffer at two, then in-order delivery.
        for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i));
        rdy = 1'b0;
        repeat (4) cycle();
        rdy = 1'b1;
        repeat (6) cycle();

        // Continuous streaming of 0..99.
        for (int i = 0; i < 100; i++) fifo_q.push_back(8'(i));
        repeat (103) cycle();

        // Pause fetching with a full buffer; stored words still drain.
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'hC0 + i));
        rdy = 1'b0;
        repeat (3) cycle();
        en = 1'b0; rdy = 1'b1;
        repeat (4) cycle();
        en = 1'b1;
        repeat (10) cycle();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8)
                fifo_q.push_back(8'($urandom));
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            cycle();
        end

        // Mid-operation reset with two words buffered.
        fifo_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h50 + i));
        en = 1'b1; rdy = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; en = 1'b0;
        repeat (2) cycle();
        en = 1'b1; rdy = 1'b1;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
